// File: rtl/foo_result_drain.sv
// foo_result_drain: captures foo lane/long results into a snapshot FIFO and streams each snapshot as WIDTH-bit words.
// Empty-FIFO outputs are forced to zero so reset and idle present an all-zero interface.
module foo_result_drain #(
  parameter int LANES      = 2,
  parameter int WIDTH      = 64,
  parameter int LONG_WIDTH = 129,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_valid,
  input  logic [LANES*WIDTH-1:0] x_in,
  input  logic [LONG_WIDTH-1:0]  long_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [7:0]             out_seq,
  output logic                   full,
  output logic [15:0]            drop_cnt
);
  localparam int LW    = (LONG_WIDTH + WIDTH - 1) / WIDTH;
  localparam int LPW   = LW * WIDTH;
  localparam int WORDS = LANES + LW;
  localparam int SW    = WORDS * WIDTH;
  localparam int IW    = $clog2(WORDS);
  localparam int PW    = $clog2(DEPTH);
  logic [SW-1:0] mem_q [DEPTH];
  logic [7:0]    seq_mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    seq_q;
  logic [15:0]   drop_q;
  logic          push, pop, xfer, last;
  logic [SW-1:0] snap_d;
  // Lanes occupy the low words, the zero-extended long bus the high words.
  assign snap_d    = {LPW'(long_in), x_in};
  assign out_valid = cnt_q != '0;
  assign full      = cnt_q == (PW+1)'(DEPTH);
  assign last      = idx_q == IW'(WORDS - 1);
  assign out_last  = out_valid && last;
  assign xfer      = out_valid && out_ready;
  assign push      = cap_valid && !full;
  assign pop       = xfer && last;
  assign out_data  = out_valid ? mem_q[rd_q][idx_q*WIDTH +: WIDTH] : '0;
  assign out_seq   = out_valid ? seq_mem_q[rd_q] : '0;
  assign drop_cnt  = drop_q;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q]     <= snap_d;
      seq_mem_q[wr_q] <= seq_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push);
      rd_q  <= rd_q + PW'(pop);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      seq_q <= seq_q + 8'(push);
      if (xfer) idx_q <= last ? '0 : idx_q + 1'b1;
      if (cap_valid && full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_foo_result_drain.sv
// tb_foo_result_drain: table-driven captures plus corner sequences, checked by a snapshot scoreboard.
module tb_foo_result_drain;
  logic clk = 0, rst_n = 0, cap_valid = 0, out_ready = 0;
  logic [127:0] x_in = '0;
  logic [128:0] long_in = '0;
  logic out_valid, out_last, full;
  logic [63:0] out_data;
  logic [7:0] out_seq;
  logic [15:0] drop_cnt;
  int checks = 0, errors = 0;
  typedef struct packed {logic [4:0][63:0] w; logic [7:0] seq;} snap_t;
  typedef struct packed {logic [63:0] x0, x1; logic [128:0] lng; logic [4:0][63:0] w;} vec_t;
  vec_t vecs [4];
  snap_t sb [$];
  logic [4:0][63:0] exp_w = '0;
  logic [7:0] m_seq = '0;
  logic [15:0] m_drop = '0;
  int m_idx = 0;

  always #5 clk = ~clk;

  foo_result_drain dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .x_in(x_in), .long_in(long_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_seq(out_seq), .full(full), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][63:0] split(input logic [63:0] a, input logic [63:0] b, input logic [128:0] l);
    return {64'(l[128]), l[127:64], l[63:0], b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [63:0] a, input logic [63:0] b, input logic [128:0] l, input logic [4:0][63:0] e);
    x_in = {b, a};
    long_in = l;
    exp_w = e;
    cap_valid = 1;
    tick();
    cap_valid = 0;
  endtask

  task automatic capm(input logic [63:0] a, input logic [63:0] b, input logic [128:0] l);
    cap(a, b, l, split(a, b, l));
  endtask

  task automatic capr();
    logic [63:0] a, b;
    logic [128:0] l;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    l = {1'($urandom), $urandom, $urandom, $urandom, $urandom};
    capm(a, b, l);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((out_valid || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < 200), 1);
  endtask

  task automatic wait_last();
    int n = 0;
    while (!out_last && n < 20) begin
      tick();
      n++;
    end
    check("wait_last_timeout", 64'(out_last), 1);
  endtask

  task automatic monitor();
    logic pv = 0, pl = 0;
    logic [63:0] pd = '0;
    logic [7:0] ps = '0;
    snap_t s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        m_seq = 0;
        m_drop = 0;
        m_idx = 0;
        pv = 0;
      end else begin
        check("valid", 64'(out_valid), 64'(sb.size() != 0));
        check("full", 64'(full), 64'(sb.size() == 4));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (pv) begin
          check("hold_data", out_data, pd);
          check("hold_last", 64'(out_last), 64'(pl));
          check("hold_seq", 64'(out_seq), 64'(ps));
        end
        if (out_valid && sb.size() != 0) begin
          check("data", out_data, sb[0].w[m_idx]);
          check("last", 64'(out_last), 64'(m_idx == 4));
          check("seq", 64'(out_seq), 64'(sb[0].seq));
        end
        pv = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
        ps = out_seq;
        if (cap_valid) begin
          if (sb.size() < 4) begin
            s.w = exp_w;
            s.seq = m_seq;
            sb.push_back(s);
            m_seq++;
          end else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (out_valid && out_ready) begin
          if (m_idx == 4) begin
            m_idx = 0;
            if (sb.size() != 0) void'(sb.pop_front());
          end else m_idx++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    fork monitor(); join_none
    vecs[0] = '{x0: 64'h1111, x1: 64'h2222, lng: {1'b1, 64'hAAAA, 64'hBBBB},
                w: {64'h1, 64'hAAAA, 64'hBBBB, 64'h2222, 64'h1111}};
    vecs[1] = '{x0: 64'hFFFF_FFFF_FFFF_FFFF, x1: 64'h0,
                lng: {1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210},
                w: {64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
    vecs[2] = '{x0: 64'hDEAD_BEEF_0000_0001, x1: 64'h8000_0000_0000_0000, lng: {129{1'b1}},
                w: {64'h1, {64{1'b1}}, {64{1'b1}}, 64'h8000_0000_0000_0000, 64'hDEAD_BEEF_0000_0001}};
    vecs[3] = '{x0: 64'h0, x1: 64'h1, lng: {1'b0, 64'h0, 64'h8000_0000_0000_0001},
                w: {64'h0, 64'h0, 64'h8000_0000_0000_0001, 64'h1, 64'h0}};
    rst_n = 0;
    tick();
    check("rst_valid", 64'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_last", 64'(out_last), 0);
    check("rst_seq", 64'(out_seq), 0);
    check("rst_full", 64'(full), 0);
    check("rst_drop", 64'(drop_cnt), 0);
    rst_n = 1;
    tick();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cap(vecs[i].x0, vecs[i].x1, vecs[i].lng, vecs[i].w);
      if (i == 0) begin
        check("lat_valid", 64'(out_valid), 1);
        check("lat_data", out_data, 64'h1111);
        check("first_seq", 64'(out_seq), 0);
      end
      drain();
    end
    do_reset();
    out_ready = 0;
    cap(vecs[0].x0, vecs[0].x1, vecs[0].lng, vecs[0].w);
    n = 0;
    while (out_valid && n < 30) begin
      tick();
      out_ready = ~out_ready;
      n++;
    end
    check("bp_cycles", 64'(n), 10);
    out_ready = 0;
    tick();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      capm(64'(i), 64'(i + 100), 129'(i + 200));
      if (i == 2) check("ovf_full3", 64'(full), 0);
      if (i == 3) check("ovf_full4", 64'(full), 1);
    end
    check("ovf_drop", 64'(drop_cnt), 2);
    drain();
    out_ready = 0;
    capr();
    check("ovf_next_seq", 64'(out_seq), 4);
    drain();
    do_reset();
    out_ready = 0;
    repeat (4) capr();
    check("sim_full", 64'(full), 1);
    out_ready = 1;
    wait_last();
    capr();
    out_ready = 0;
    check("sim_full_drop", 64'(drop_cnt), 1);
    check("sim_full_cnt3", 64'(full), 0);
    out_ready = 1;
    wait_last();
    capr();
    out_ready = 0;
    check("sim3_drop", 64'(drop_cnt), 1);
    check("sim3_notfull", 64'(full), 0);
    capr();
    check("sim3_cnt4", 64'(full), 1);
    drain();
    do_reset();
    out_ready = 0;
    repeat (2) capr();
    out_ready = 1;
    repeat (3) tick();
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", 64'(out_last), 0);
    check("mid_rst_seq", 64'(out_seq), 0);
    check("mid_rst_full", 64'(full), 0);
    tick();
    tick();
    rst_n = 1;
    repeat (3) tick();
    check("post_rst_idle", 64'(out_valid), 0);
    capr();
    check("post_rst_valid", 64'(out_valid), 1);
    check("post_rst_seq", 64'(out_seq), 0);
    drain();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 257; i++) begin
      capr();
      if (i == 255) check("wrap_seq255", 64'(out_seq), 255);
      if (i == 256) check("wrap_seq0", 64'(out_seq), 0);
      repeat (5) tick();
    end
    check("wrap_drop", 64'(drop_cnt), 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
